// File: rtl/rv32ima_pkg.sv
// Shared types and constants for the RV32IMA core's data-memory interface.
package rv32ima_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MOP_NORMAL = 2'd0,
        MOP_LR     = 2'd1,
        MOP_SC     = 2'd2
    } mem_op_t;

    // Encoding 3 is left unnamed in mem_op_t and is always reported as a fault.
    localparam logic [1:0] MOP_RESERVED = 2'd3;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dmem_state_t;

    localparam word_t SC_SUCCESS = 32'd0;
    localparam word_t SC_FAIL    = 32'd1;

endpackage

// File: rtl/sram_1rw.sv
// Single-port word RAM: 1-cycle synchronous read, per-byte write enables, no reset.
module sram_1rw
    import rv32ima_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       we,
    input  word_t            wdata,
    output word_t            rdata
);

    word_t mem [DEPTH_WORDS];

    // Read-first: rdata shows the word as it was before any write on the same edge.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, programmable wait states,
// byte-strobed stores and an LR/SC reservation on top of a synchronous word RAM.
module dmem_responder
    import rv32ima_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  word_t       req_addr,
    input  logic        req_wen,
    input  logic [3:0]  req_be,
    input  word_t       req_wdata,
    input  logic [1:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output word_t       rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t      state, state_next;
    logic [3:0]       wait_cnt;
    logic [IDX_W-1:0] cap_idx;
    logic [1:0]       cap_op;
    logic             cap_wen;
    logic [3:0]       cap_be;
    word_t            cap_wdata;
    logic             cap_fault;
    logic             resv_valid;
    logic [IDX_W-1:0] resv_addr;
    logic             rsp_err_q;
    logic             rsp_from_ram;
    word_t            rsp_word_q;

    logic             accept;
    logic             wait_done;
    logic             req_fault;
    logic             resv_hit;
    logic             is_load, is_store, is_lr, is_sc;
    logic             ram_en;
    logic [3:0]       ram_we;
    word_t            ram_rdata;

    // The upper address bits take part in the range check so aliasing addresses fault.
    assign req_fault = (req_addr[1:0] != 2'b00)
                    || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS))
                    || (req_op == MOP_RESERVED);

    assign wait_done = (state == DM_WAIT) && (wait_cnt == 4'(WAIT_STATES));
    assign resv_hit  = resv_valid && (resv_addr == cap_idx);
    assign is_load   = (cap_op == MOP_NORMAL) && !cap_wen;
    assign is_store  = (cap_op == MOP_NORMAL) && cap_wen;
    assign is_lr     = (cap_op == MOP_LR);
    assign is_sc     = (cap_op == MOP_SC);

    always_ff @(posedge clk) begin
        if (nrst) begin
            state <= DM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            DM_IDLE: begin
                req_ready = !nrst;
                if (req_valid && !nrst) begin
                    state_next = DM_WAIT;
                end
            end
            DM_WAIT: begin
                if (wait_done) begin
                    state_next = DM_RESP;
                end
            end
            DM_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = DM_IDLE;
                end
            end
            default: state_next = DM_IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    // All RAM writes land on the final WAIT edge; a reset cycle never commits one.
    always_comb begin
        ram_we = 4'h0;
        if (wait_done && !cap_fault && !nrst) begin
            if (is_store) begin
                ram_we = cap_be;
            end else if (is_sc && resv_hit) begin
                ram_we = 4'hF;
            end
        end
    end

    assign ram_en = (state == DM_WAIT);

    always_ff @(posedge clk) begin
        if (nrst) begin
            wait_cnt     <= 4'd0;
            resv_valid   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_from_ram <= 1'b0;
            rsp_word_q   <= '0;
        end else begin
            if (accept) begin
                cap_idx   <= req_addr[IDX_W+1:2];
                cap_op    <= req_op;
                cap_wen   <= req_wen;
                cap_be    <= req_be;
                cap_wdata <= req_wdata;
                cap_fault <= req_fault;
                wait_cnt  <= 4'd0;
            end else if ((state == DM_WAIT) && !wait_done) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (wait_done) begin
                rsp_err_q    <= cap_fault;
                rsp_from_ram <= !cap_fault && (is_load || is_lr);
                rsp_word_q   <= (!cap_fault && is_sc && !resv_hit) ? SC_FAIL : SC_SUCCESS;
                if (!cap_fault) begin
                    if (is_lr) begin
                        resv_valid <= 1'b1;
                        resv_addr  <= cap_idx;
                    end else if (is_sc || (is_store && resv_hit)) begin
                        resv_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign rsp_err   = rsp_valid && rsp_err_q;
    assign rsp_rdata = !rsp_valid   ? '0
                     : rsp_from_ram ? ram_rdata
                     :                rsp_word_q;

    sram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .addr  (cap_idx),
        .we    (ram_we),
        .wdata (cap_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized
// run, all checked against a word-array model with an LR/SC reservation.
module tb_dmem_responder;
    import rv32ima_pkg::*;

    localparam int DEPTH = 1024;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_resv_valid = 1'b0;
    int          model_resv_idx = 0;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_access(input logic [1:0] op, input logic [31:0] addr, input logic wen,
                                input logic [3:0] be, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
        int idx;
        if (addr[1:0] != 2'b00 || (addr >> 2) >= 32'(DEPTH) || op == 2'd3) begin
            rdata = 32'd0;
            err   = 1'b1;
            return;
        end
        idx = int'(addr >> 2);
        err = 1'b0;
        case (op)
            2'd0: begin
                if (wen) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                    if (model_resv_valid && model_resv_idx == idx) model_resv_valid = 1'b0;
                    rdata = 32'd0;
                end else begin
                    rdata = model_mem[idx];
                end
            end
            2'd1: begin
                rdata = model_mem[idx];
                model_resv_valid = 1'b1;
                model_resv_idx = idx;
            end
            default: begin
                if (model_resv_valid && model_resv_idx == idx) begin
                    model_mem[idx] = wdata;
                    rdata = 32'd0;
                end else begin
                    rdata = 32'd1;
                end
                model_resv_valid = 1'b0;
            end
        endcase
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [31:0] addr, input logic wen,
                             input logic [3:0] be, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wen   = wen;
        req_be    = be;
        req_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        req_wen   = 1'($urandom);
        req_op    = 2'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic complete_rsp(input int hold, output logic [31:0] rdata, output logic err);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [31:0] addr, input logic wen,
                          input logic [3:0] be, input logic [31:0] wdata, input int hold,
                          output logic [31:0] got_r, output logic got_e, output int lat,
                          output logic [31:0] exp_r, output logic exp_e);
        model_access(op, addr, wen, be, wdata, exp_r, exp_e);
        drive_req(op, addr, wen, be, wdata);
        wait_rsp(lat);
        complete_rsp(hold, got_r, got_e);
    endtask

    task automatic test_reset();
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h40;
        req_be    = 4'hF;
        req_wdata = 32'hBAD0BAD0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_req_ready: got %b want 0", req_ready);
        end
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        vectors++;
        if (rsp_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp_err: got %b want 0", rsp_err);
        end
        nrst = 1'b0;
        req_valid = 1'b0;
        model_resv_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic init_mem();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        for (int w = 0; w < 16; w++)
            do_txn(2'd0, 32'(w * 4), 1'b1, 4'hF, $urandom, 0, r, e, lat, er, ee);
    endtask

    task automatic test_store_load();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        do_txn(2'd0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== 32'd0 || e !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store_rsp: got rdata=%h err=%b want 00000000/0", r, e);
        end
        vectors++;
        if (lat !== WS + 1) begin
            miscompares++;
            $display("[TB] FAIL store_latency: got %0d want %0d", lat, WS + 1);
        end
        do_txn(2'd0, 32'h10, 1'b0, 4'h0, 32'h0, 1, r, e, lat, er, ee);
        vectors++;
        if (r !== 32'hDEADBEEF || e !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_rdata: got %h err=%b want deadbeef/0", r, e);
        end
        vectors++;
        if (lat !== WS + 1) begin
            miscompares++;
            $display("[TB] FAIL load_latency: got %0d want %0d", lat, WS + 1);
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        do_txn(2'd0, 32'h10, 1'b1, 4'b0101, 32'h11223344, 0, r, e, lat, er, ee);
        do_txn(2'd0, 32'h10, 1'b0, 4'h0, 32'h0, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== 32'hDE22BE44) begin
            miscompares++;
            $display("[TB] FAIL byte_strobe: got %h want de22be44", r);
        end
        do_txn(2'd0, 32'h14, 1'b1, 4'h0, 32'hFFFFFFFF, 0, r, e, lat, er, ee);
        do_txn(2'd0, 32'h14, 1'b0, 4'h0, 32'h0, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== er) begin
            miscompares++;
            $display("[TB] FAIL be_zero_noop: got %h want %h", r, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] er, r;
        logic ee, e;
        int lat;
        model_access(2'd0, 32'h10, 1'b0, 4'h0, 32'h0, er, ee);
        drive_req(2'd0, 32'h10, 1'b0, 4'h0, 32'h0);
        wait_rsp(lat);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h10;
        req_be    = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== ee || req_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL backpressure_cycle%0d: got valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready, er, ee);
            end
        end
        req_valid = 1'b0;
        complete_rsp(0, r, e);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL backpressure_release: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_faults();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        logic [31:0] fa [3];
        logic [1:0]  fo [3];
        logic [31:0] rb [3];
        fa[0] = 32'h12;           fo[0] = 2'd0; rb[0] = 32'h10;
        fa[1] = 32'(DEPTH * 4);   fo[1] = 2'd0; rb[1] = 32'h0;
        fa[2] = 32'h10;           fo[2] = 2'd3; rb[2] = 32'h10;
        for (int k = 0; k < 3; k++) begin
            do_txn(fo[k], fa[k], 1'b1, 4'hF, 32'hA5A5A5A5, 0, r, e, lat, er, ee);
            vectors++;
            if (e !== 1'b1 || r !== 32'd0 || lat !== WS + 1) begin
                miscompares++;
                $display("[TB] FAIL fault%0d_rsp: got err=%b rdata=%h lat=%0d want 1/00000000/%0d",
                         k, e, r, lat, WS + 1);
            end
            do_txn(2'd0, rb[k], 1'b0, 4'h0, 32'h0, 0, r, e, lat, er, ee);
            vectors++;
            if (r !== er || e !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL fault%0d_readback: got %h want %h", k, r, er);
            end
        end
    endtask

    task automatic test_lr_sc();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        do_txn(2'd1, 32'h20, 1'b0, 4'h0, 32'h0, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== er || e !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lr_rdata: got %h want %h", r, er);
        end
        do_txn(2'd2, 32'h20, 1'b0, 4'h0, 32'd5, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL sc_success: got %h want 00000000", r);
        end
        do_txn(2'd0, 32'h20, 1'b0, 4'h0, 32'h0, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== 32'd5) begin
            miscompares++;
            $display("[TB] FAIL sc_success_write: got %h want 00000005", r);
        end
        do_txn(2'd1, 32'h20, 1'b0, 4'h0, 32'h0, 0, r, e, lat, er, ee);
        do_txn(2'd0, 32'h20, 1'b1, 4'hF, 32'd7, 0, r, e, lat, er, ee);
        do_txn(2'd2, 32'h20, 1'b0, 4'h0, 32'd9, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL sc_after_store: got %h want 00000001", r);
        end
        do_txn(2'd0, 32'h20, 1'b0, 4'h0, 32'h0, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== 32'd7) begin
            miscompares++;
            $display("[TB] FAIL sc_fail_nowrite: got %h want 00000007", r);
        end
        do_txn(2'd2, 32'h24, 1'b0, 4'h0, 32'd3, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL sc_no_lr: got %h want 00000001", r);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        do_txn(2'd0, 32'h40, 1'b1, 4'hF, 32'h600DF00D, 0, r, e, lat, er, ee);
        drive_req(2'd0, 32'h40, 1'b1, 4'hF, 32'hBAADBAAD);
        @(negedge clk);
        nrst      = 1'b1;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_op    = 2'd0;
        req_addr  = 32'h40;
        req_be    = 4'hF;
        req_wdata = 32'hBAADBAAD;
        repeat (2) @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midflight_reset_outputs: got valid=%b ready=%b want 0/0", rsp_valid, req_ready);
        end
        nrst = 1'b0;
        req_valid = 1'b0;
        model_resv_valid = 1'b0;
        do_txn(2'd0, 32'h40, 1'b0, 4'h0, 32'h0, 0, r, e, lat, er, ee);
        vectors++;
        if (r !== 32'h600DF00D) begin
            miscompares++;
            $display("[TB] FAIL midflight_no_write: got %h want 600df00d", r);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er, addr;
        logic e, ee, wen;
        logic [1:0] op;
        int lat, sel;
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            wen = 1'b0;
            if (sel <= 3)      op = 2'd0;
            else if (sel <= 6) begin op = 2'd0; wen = 1'b1; end
            else if (sel == 7) op = 2'd1;
            else if (sel == 8) op = 2'd2;
            else               op = 2'd3;
            addr = 32'($urandom_range(0, 7) * 4);
            sel = $urandom_range(0, 19);
            if (sel < 2)       addr = addr + 32'($urandom_range(1, 3));
            else if (sel == 2) addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
            else if (sel == 3) addr = 32'hFFFFFFFC;
            do_txn(op, addr, wen, 4'($urandom), $urandom, $urandom_range(0, 3), r, e, lat, er, ee);
            vectors++;
            if (r !== er || e !== ee || lat !== WS + 1) begin
                miscompares++;
                $display("[TB] FAIL random%0d op=%0d addr=%h wen=%b: got rdata=%h err=%b lat=%0d want %h/%b/%0d",
                         n, op, addr, wen, r, e, lat, er, ee, WS + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_store_load();
        test_byte_strobe();
        test_backpressure();
        test_faults();
        test_lr_sc();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
